// File: rtl/dwt_dma_pkg.sv
// Shared AXI encodings, burst limits and AR generator state encoding for the DWT DMA.
package dwt_dma_pkg;

    typedef enum logic [1:0] {
        Fixed = 2'd0,
        Incr  = 2'd1,
        Wrap  = 2'd2
    } axi_burst_e;

    typedef enum logic [2:0] {
        Byte1 = 3'd0,
        Byte2 = 3'd1,
        Byte4 = 3'd2,
        Byte8 = 3'd3
    } axi_size_e;

    typedef enum logic [3:0] {
        DeviceNonBuff     = 4'b0000,
        NormalNonCachBuff = 4'b0011
    } axi_cache_e;

    localparam int BOUNDARY_BYTES  = 4096;
    localparam int MAX_BURST_BEATS = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ADDR  = 2'd2,
        DRAIN = 2'd3
    } ar_state_e;

endpackage

// File: rtl/dwt_dma_ar_gen.sv
// Splits a byte-length read command into 4 KB-safe AXI INCR bursts; first arvalid two cycles after accept.
// Stalls in CALC while MAX_OUTSTANDING bursts await rlast; holds AR stable until arready.
module dwt_dma_ar_gen
    import dwt_dma_pkg::*;
#(
    parameter int DMA_AXI_ADDR_WIDTH = 32,
    parameter int DMA_DATA_WIDTH_SRC = 64,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DMA_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_bytes,
    output logic [DMA_AXI_ADDR_WIDTH-1:0] m_src_axi_araddr,
    output logic [7:0]                    m_src_axi_arlen,
    output logic [2:0]                    m_src_axi_arsize,
    output logic [1:0]                    m_src_axi_arburst,
    output logic                          m_src_axi_arvalid,
    input  logic                          m_src_axi_arready,
    input  logic                          m_src_axi_rvalid,
    input  logic                          m_src_axi_rready,
    input  logic                          m_src_axi_rlast,
    output logic                          busy,
    output logic                          done
);

    localparam int AW             = DMA_AXI_ADDR_WIDTH;
    localparam int BEAT_BYTES     = DMA_DATA_WIDTH_SRC / 8;
    localparam int BOUNDARY_BEATS = BOUNDARY_BYTES / BEAT_BYTES;
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1);

    ar_state_e        state;
    logic [AW-1:0]    addr;
    logic [28:0]      beats;
    logic [8:0]       len_beats;
    logic [8:0]       next_len;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic             ar_hs;
    logic             r_last_hs;
    logic             unused_low_bits;

    assign unused_low_bits   = ^{cmd_addr[2:0], cmd_bytes[2:0]};
    assign m_src_axi_arsize  = Byte8;
    assign m_src_axi_arburst = Incr;

    assign ar_hs     = m_src_axi_arvalid & m_src_axi_arready;
    assign r_last_hs = m_src_axi_rvalid & m_src_axi_rready & m_src_axi_rlast;

    // Burst length: remaining beats, capped by max burst and by beats left before the next 4 KB line.
    function automatic logic [8:0] calc_burst(input logic [AW-1:0] a, input logic [28:0] b);
        logic [9:0] to_boundary;
        logic [9:0] lim;
        to_boundary = 10'(BOUNDARY_BEATS) - {1'b0, a[11:3]};
        lim = (to_boundary > 10'(MAX_BURST_BEATS)) ? 10'(MAX_BURST_BEATS) : to_boundary;
        if (b < 29'(lim)) begin
            return b[8:0];
        end
        return lim[8:0];
    endfunction

    assign next_len = calc_burst(addr, beats);

    // Stray rlast with nothing outstanding (e.g. after a reset) saturates at zero.
    always_comb begin
        outstanding_nxt = outstanding;
        if (ar_hs && !r_last_hs) begin
            outstanding_nxt = outstanding + CNT_W'(1);
        end else if (!ar_hs && r_last_hs && (outstanding != '0)) begin
            outstanding_nxt = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state             <= IDLE;
            addr              <= '0;
            beats             <= '0;
            len_beats         <= '0;
            outstanding       <= '0;
            m_src_axi_arvalid <= 1'b0;
            m_src_axi_araddr  <= '0;
            m_src_axi_arlen   <= '0;
            cmd_ready         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        addr      <= {cmd_addr[AW-1:3], 3'b000};
                        beats     <= cmd_bytes[31:3];
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (beats == '0) begin
                        state <= DRAIN;
                    end else if (outstanding < CNT_W'(MAX_OUTSTANDING)) begin
                        len_beats         <= next_len;
                        m_src_axi_araddr  <= addr;
                        m_src_axi_arlen   <= 8'(next_len - 9'd1);
                        m_src_axi_arvalid <= 1'b1;
                        state             <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        m_src_axi_arvalid <= 1'b0;
                        addr              <= addr + (AW'(len_beats) * AW'(BEAT_BYTES));
                        beats             <= beats - 29'(len_beats);
                        state             <= CALC;
                    end
                end
                DRAIN: begin
                    // Look at the post-update count so done lands one cycle after the final rlast.
                    if (outstanding_nxt == '0) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dwt_dma_ar_gen.sv
// Directed latency/boundary/backpressure/reset scenarios, then random commands checked against a burst-list model.
module tb_dwt_dma_ar_gen;

    localparam int AW   = 32;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_bytes;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    int unsigned exp_a[$];
    int unsigned exp_l[$];

    dwt_dma_ar_gen #(
        .DMA_AXI_ADDR_WIDTH(AW),
        .DMA_DATA_WIDTH_SRC(64),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .m_axi_aclk       (clk),
        .m_axi_areset     (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_bytes        (cmd_bytes),
        .m_src_axi_araddr (araddr),
        .m_src_axi_arlen  (arlen),
        .m_src_axi_arsize (arsize),
        .m_src_axi_arburst(arburst),
        .m_src_axi_arvalid(arvalid),
        .m_src_axi_arready(arready),
        .m_src_axi_rvalid (rvalid),
        .m_src_axi_rready (rready),
        .m_src_axi_rlast  (rlast),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the accepting edge.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_bytes = b;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_bytes = $urandom;
    endtask

    task automatic pulse_rlast();
        rvalid = 1'b1;
        rready = 1'b1;
        rlast  = 1'b1;
        tick();
        rvalid = 1'b0;
        rready = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic wait_ar(input string tag);
        int n;
        n = 0;
        while (arvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, arvalid, 1);
    endtask

    task automatic expect_ar(input string tag, input logic [31:0] a, input logic [7:0] l);
        chk({tag, "_araddr"}, araddr, a);
        chk({tag, "_arlen"}, arlen, l);
        chk({tag, "_arsize"}, arsize, 3);
        chk({tag, "_arburst"}, arburst, 1);
    endtask

    // Reference burst list: plain arithmetic on bytes, 4 KB lines and the 256-beat cap.
    task automatic build_exp(input logic [31:0] a, input logic [31:0] b);
        int unsigned cur;
        int unsigned n;
        int unsigned room;
        int unsigned l;
        exp_a.delete();
        exp_l.delete();
        cur = a - (a % 8);
        n   = b / 8;
        while (n > 0) begin
            room = (4096 - (cur % 4096)) / 8;
            l = n;
            if (l > 256) l = 256;
            if (l > room) l = room;
            exp_a.push_back(cur);
            exp_l.push_back(l - 1);
            cur = cur + l * 8;
            n   = n - l;
        end
    endtask

    task automatic run_random(input logic [31:0] a, input logic [31:0] b);
        int          pend;
        int          cyc;
        bit          done_seen;
        bit          hold;
        logic [31:0] hold_a;
        logic [7:0]  hold_l;
        bit          hs;
        bit          rl;
        build_exp(a, b);
        send_cmd(a, b);
        pend = 0;
        cyc = 0;
        done_seen = 0;
        hold = 0;
        hold_a = '0;
        hold_l = '0;
        while (!done_seen && cyc < 4000) begin
            arready   = 1'b0;
            rvalid    = 1'b0;
            rready    = 1'b0;
            rlast     = 1'b0;
            cmd_valid = 1'b0;
            if (hold) begin
                chk("rnd_hold_arvalid", arvalid, 1);
                chk("rnd_hold_araddr", araddr, hold_a);
                chk("rnd_hold_arlen", arlen, hold_l);
            end
            hold = 0;
            if (done === 1'b1) begin
                done_seen = 1;
                chk("rnd_done_all_ars", exp_a.size(), 0);
                chk("rnd_done_outstanding", pend, 0);
                chk("rnd_done_busy", busy, 0);
            end else begin
                if (cmd_ready === 1'b0) begin
                    cmd_valid = $urandom_range(0, 1);
                end
                arready = ($urandom_range(0, 3) != 0);
                hs = 0;
                if (arvalid === 1'b1) begin
                    if (arready) begin
                        hs = 1;
                        chk("rnd_outstanding_limit", pend < MAXO, 1);
                        chk("rnd_ar_expected", exp_a.size() > 0, 1);
                        if (exp_a.size() > 0) begin
                            chk("rnd_araddr", araddr, exp_a.pop_front());
                            chk("rnd_arlen", arlen, exp_l.pop_front());
                        end
                    end else begin
                        hold = 1;
                        hold_a = araddr;
                        hold_l = arlen;
                    end
                end
                rl = (pend > 0) && ($urandom_range(0, 2) == 0);
                if (rl) begin
                    rvalid = 1'b1;
                    rready = 1'b1;
                    rlast  = 1'b1;
                end else begin
                    rvalid = $urandom_range(0, 1);
                    rready = $urandom_range(0, 1);
                    rlast  = (rvalid && rready) ? 1'b0 : 1'($urandom_range(0, 1));
                end
                pend = pend + int'(hs) - int'(rl);
            end
            tick();
            cyc++;
        end
        arready = 1'b0;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        cmd_valid = 1'b0;
        chk("rnd_done_seen", done_seen, 1);
        chk("rnd_done_single", done, 0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] spec_a[4];
        logic [31:0] spec_b[4];

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_bytes = '0;
        arready = 1'b0;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        repeat (3) tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", cmd_ready, 1);

        // Single 256-beat burst, accept-to-arvalid latency, done after rlast
        send_cmd(32'h1000, 2048);
        chk("t1_n1_arvalid", arvalid, 0);
        chk("t1_n1_busy", busy, 1);
        chk("t1_n1_cmd_ready", cmd_ready, 0);
        tick();
        chk("t1_n2_arvalid", arvalid, 1);
        expect_ar("t1", 32'h1000, 8'd255);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("t1_arvalid_drop", arvalid, 0);
        repeat (4) tick();
        chk("t1_no_extra_ar", arvalid, 0);
        chk("t1_wait_done", done, 0);
        chk("t1_wait_busy", busy, 1);
        pulse_rlast();
        chk("t1_done", done, 1);
        tick();
        chk("t1_done_once", done, 0);
        chk("t1_ready_back", cmd_ready, 1);

        // Zero-length command
        send_cmd(32'h2340, 32'd7);
        chk("z_n1_arvalid", arvalid, 0);
        chk("z_n1_done", done, 0);
        tick();
        chk("z_n2_arvalid", arvalid, 0);
        chk("z_n2_done", done, 0);
        tick();
        chk("z_n3_done", done, 1);
        tick();
        chk("z_n4_done", done, 0);
        chk("z_n4_cmd_ready", cmd_ready, 1);
        chk("z_n4_busy", busy, 0);

        // 4 KB split with arready held low
        send_cmd(32'h1F00, 1024);
        tick();
        chk("b0_arvalid", arvalid, 1);
        expect_ar("b0", 32'h1F00, 8'd31);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b0_stall_arvalid", arvalid, 1);
            chk("b0_stall_araddr", araddr, 32'h1F00);
            chk("b0_stall_arlen", arlen, 31);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("b0_single_hs", arvalid, 0);
        tick();
        chk("b1_arvalid", arvalid, 1);
        expect_ar("b1", 32'h2000, 8'd95);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        repeat (3) tick();
        chk("b_no_extra_ar", arvalid, 0);
        pulse_rlast();
        chk("b_done_early", done, 0);
        pulse_rlast();
        chk("b_done", done, 1);
        tick();

        // Outstanding limit with rlast withheld
        arready = 1'b1;
        send_cmd(32'h0, 8192);
        tick();
        chk("o0_arvalid", arvalid, 1);
        expect_ar("o0", 32'h0, 8'd255);
        tick();
        tick();
        chk("o1_arvalid", arvalid, 1);
        expect_ar("o1", 32'h800, 8'd255);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("o_stalled", arvalid, 0);
        end
        for (int k = 2; k < 4; k++) begin
            pulse_rlast();
            wait_ar("o_release");
            expect_ar("o_next", k * 32'h800, 8'd255);
            tick();
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("o_stalled_again", arvalid, 0);
            end
        end
        arready = 1'b0;
        pulse_rlast();
        chk("o_done_early", done, 0);
        pulse_rlast();
        chk("o_done", done, 1);
        tick();

        // Reset during second burst, stray rlasts, then a clean command
        send_cmd(32'h1F00, 1024);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        tick();
        chk("r_second_arvalid", arvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_mid_arvalid", arvalid, 0);
        chk("r_mid_busy", busy, 0);
        chk("r_mid_done", done, 0);
        pulse_rlast();
        pulse_rlast();
        send_cmd(32'h1000, 2048);
        wait_ar("r_new_ar");
        expect_ar("r_new", 32'h1000, 8'd255);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        repeat (3) tick();
        pulse_rlast();
        chk("r_new_done", done, 1);
        tick();

        // Random commands, led by boundary and wrap cases
        spec_a[0] = 32'hFFFF_FF00; spec_b[0] = 32'd1024;
        spec_a[1] = 32'h0000_0FF8; spec_b[1] = 32'd16;
        spec_a[2] = 32'h0000_1003; spec_b[2] = 32'd15;
        spec_a[3] = 32'h0001_0000; spec_b[3] = 32'd4096;
        for (int i = 0; i < 4; i++) begin
            run_random(spec_a[i], spec_b[i]);
        end
        for (int i = 0; i < 36; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                ra[11:0] = 12'(12'hFFF - 12'($urandom_range(0, 600)));
            end
            rb = $urandom_range(0, 5000);
            run_random(ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
